img2col_top: RTL and testbench

- Streaming image-to-column converter for the patch-embedding front end.
- Accepts a feature map as 64-bit beats, each beat holding 8 one-byte channels. Input order is row-major, then column, then channel group.
- Buffers Kernel_Size input rows and re-emits each output row's patches as flattened kernel windows to the downstream matrix engine.
- Window and stride geometry are run-time inputs, latched on start.

---
 rtl/img2col_top.sv | 227 ++++++++++++++++++++++
 tb/tb_img2col_top.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/img2col_top.sv
`default_nettype none
// ============================================================================
// Module : img2col_top
// Brief  : Streaming image-to-column converter. Buffers kernel rows of a
//          feature map and replays each output row as flattened windows.
// Rev    : 1.0
// ============================================================================
module img2col_top #(
    parameter int DATA_W        = 64,
    parameter int MAX_K         = 16,
    parameter int MAX_ROW_BEATS = 896,
    parameter int CFG_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sData_valid,
    output logic              sData_ready,
    input  logic [DATA_W-1:0] sData_payload,
    output logic [DATA_W-1:0] mData,
    output logic              mValid,
    input  logic              mReady,
    output logic              mLast,
    input  logic [CFG_W-1:0]  Stride,
    input  logic [CFG_W-1:0]  Kernel_Size,
    input  logic [CFG_W-1:0]  Window_Size,
    input  logic [CFG_W-1:0]  Sliding_Size,
    input  logic [CFG_W-1:0]  InFeature_Size,
    input  logic [CFG_W-1:0]  InFeature_Channel,
    input  logic [CFG_W-1:0]  OutFeature_Channel,
    input  logic [CFG_W-1:0]  OutFeature_Size,
    input  logic [CFG_W-1:0]  OutCol_Count_Times,
    input  logic [CFG_W-1:0]  InCol_Count_Times,
    input  logic [CFG_W-1:0]  OutRow_Count_Times,
    input  logic [CFG_W-1:0]  OutFeature_Channel_Count_Times,
    input  logic [CFG_W-1:0]  Test_Generate_Period,
    output logic              Test_Signal,
    output logic              Test_End
);
    localparam int DEPTH  = MAX_K * MAX_ROW_BEATS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int SLOT_W = $clog2(MAX_K);
    localparam int COL_W  = $clog2(MAX_ROW_BEATS);
    localparam logic [CFG_W-1:0] c_one     = CFG_W'(1);
    localparam logic [COL_W-1:0] c_col_one = COL_W'(1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_EMIT = 2'd2, S_DONE = 2'd3} state_t;
    state_t r_state;

    logic [CFG_W-1:0] r_stride, r_k, r_win, r_slide, r_incol, r_ofs, r_orow, r_cht, r_tgp;
    logic [CFG_W-1:0] r_in_size, r_in_ch, r_out_ch, r_out_col;
    logic [CFG_W-1:0] r_rows_left, r_out_row, r_t, r_ox, r_ky, r_w;
    logic [SLOT_W-1:0] r_wr_slot, r_rd_slot, r_base;
    logic [COL_W-1:0]  r_wr_col, r_rd_col, r_col_base;
    logic              r_s_ready;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_s1_data, r_m_data;
    logic r_s1_vld, r_s1_last, r_s1_test, r_s1_rend;
    logic r_m_valid, r_m_last, r_m_test, r_m_rend, r_test_end;

    function automatic logic [SLOT_W-1:0] f_slot_inc(input logic [SLOT_W-1:0] s,
                                                     input logic [CFG_W-1:0] k);
        return (CFG_W'(s) + c_one == k) ? '0 : SLOT_W'(CFG_W'(s) + c_one);
    endfunction

    logic              w_accept, w_issue, w_out_free, w_s1_free;
    logic              w_last_w, w_last_ky, w_last_ox, w_last_t, w_row_done;
    logic              w_tag_last, w_tag_test;
    logic [CFG_W-1:0]  w_base_sum;
    logic [SLOT_W-1:0] w_base_nxt;
    logic [COL_W-1:0]  w_col_next;
    logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
    logic              w_unused_cfg;

    assign w_accept   = (r_state == S_LOAD) && r_s_ready && sData_valid;
    assign w_out_free = !r_m_valid || mReady;
    assign w_s1_free  = !r_s1_vld || w_out_free;
    assign w_issue    = (r_state == S_EMIT) && w_s1_free;

    assign w_last_w   = (r_w + c_one == r_win);
    assign w_last_ky  = (r_ky + c_one == r_k);
    assign w_last_ox  = (r_ox + c_one == r_ofs);
    assign w_last_t   = (r_t + c_one == r_cht);
    assign w_row_done = w_last_w && w_last_ky && w_last_ox && w_last_t;
    assign w_tag_last = w_row_done && (r_out_row + c_one == r_orow);
    // Period 0 can never match since the row index is 1-based here
    assign w_tag_test = (r_out_row + c_one == r_tgp);

    // Window base slot advances by Stride rows, modulo the ring depth
    assign w_base_sum = CFG_W'(r_base) + r_stride;
    assign w_base_nxt = SLOT_W'((w_base_sum >= r_k) ? (w_base_sum - r_k) : w_base_sum);
    assign w_col_next = COL_W'(CFG_W'(r_col_base) + r_slide);

    assign w_wr_addr = ADDR_W'(r_wr_slot) * ADDR_W'(MAX_ROW_BEATS) + ADDR_W'(r_wr_col);
    assign w_rd_addr = ADDR_W'(r_rd_slot) * ADDR_W'(MAX_ROW_BEATS) + ADDR_W'(r_rd_col);

    assign w_unused_cfg = ^{r_in_size, r_in_ch, r_out_ch, r_out_col, r_incol};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_s_ready <= 1'b0;
            r_stride  <= '0; r_k   <= '0; r_win   <= '0; r_slide <= '0; r_incol <= '0;
            r_ofs     <= '0; r_orow <= '0; r_cht  <= '0; r_tgp   <= '0;
            r_in_size <= '0; r_in_ch <= '0; r_out_ch <= '0; r_out_col <= '0;
            r_rows_left <= '0; r_out_row <= '0;
            r_t <= '0; r_ox <= '0; r_ky <= '0; r_w <= '0;
            r_wr_slot <= '0; r_rd_slot <= '0; r_base <= '0;
            r_wr_col  <= '0; r_rd_col  <= '0; r_col_base <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_stride  <= Stride;          r_k     <= Kernel_Size;
                    r_win     <= Window_Size;     r_slide <= Sliding_Size;
                    r_incol   <= InCol_Count_Times;
                    r_ofs     <= OutFeature_Size; r_orow  <= OutRow_Count_Times;
                    r_cht     <= OutFeature_Channel_Count_Times;
                    r_tgp     <= Test_Generate_Period;
                    r_in_size <= InFeature_Size;  r_in_ch <= InFeature_Channel;
                    r_out_ch  <= OutFeature_Channel; r_out_col <= OutCol_Count_Times;
                    r_rows_left <= Kernel_Size;
                    r_wr_slot <= '0; r_wr_col <= '0; r_base <= '0; r_out_row <= '0;
                    r_s_ready <= 1'b1;
                    r_state   <= S_LOAD;
                end
                S_LOAD: if (w_accept) begin
                    if (CFG_W'(r_wr_col) + c_one == r_incol) begin
                        r_wr_col    <= '0;
                        r_wr_slot   <= f_slot_inc(r_wr_slot, r_k);
                        r_rows_left <= r_rows_left - c_one;
                        if (r_rows_left == c_one) begin
                            r_s_ready  <= 1'b0;
                            r_state    <= S_EMIT;
                            r_t <= '0; r_ox <= '0; r_ky <= '0; r_w <= '0;
                            r_rd_slot  <= r_base;
                            r_col_base <= '0;
                            r_rd_col   <= '0;
                        end
                    end else begin
                        r_wr_col <= r_wr_col + c_col_one;
                    end
                end
                S_EMIT: if (w_issue) begin
                    if (!w_last_w) begin
                        r_w      <= r_w + c_one;
                        r_rd_col <= r_rd_col + c_col_one;
                    end else begin
                        r_w <= '0;
                        if (!w_last_ky) begin
                            r_ky      <= r_ky + c_one;
                            r_rd_slot <= f_slot_inc(r_rd_slot, r_k);
                            r_rd_col  <= r_col_base;
                        end else begin
                            r_ky      <= '0;
                            r_rd_slot <= r_base;
                            if (!w_last_ox) begin
                                r_ox       <= r_ox + c_one;
                                r_col_base <= w_col_next;
                                r_rd_col   <= w_col_next;
                            end else begin
                                r_ox       <= '0;
                                r_col_base <= '0;
                                r_rd_col   <= '0;
                                if (!w_last_t) begin
                                    r_t <= r_t + c_one;
                                end else begin
                                    r_t       <= '0;
                                    r_out_row <= r_out_row + c_one;
                                    r_base    <= w_base_nxt;
                                    if (w_tag_last) begin
                                        r_state <= S_DONE;
                                    end else begin
                                        r_state     <= S_LOAD;
                                        r_s_ready   <= 1'b1;
                                        r_rows_left <= r_stride;
                                    end
                                end
                            end
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line buffer: synchronous write port, synchronous read into stage 1
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[w_wr_addr] <= sData_payload;
        if (w_issue)  r_s1_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_vld <= 1'b0; r_s1_last <= 1'b0; r_s1_test <= 1'b0; r_s1_rend <= 1'b0;
            r_m_valid <= 1'b0; r_m_data <= '0; r_m_last <= 1'b0;
            r_m_test  <= 1'b0; r_m_rend <= 1'b0; r_test_end <= 1'b0;
        end else begin
            if (w_issue) begin
                r_s1_vld  <= 1'b1;
                r_s1_last <= w_tag_last;
                r_s1_test <= w_tag_test;
                r_s1_rend <= w_row_done;
            end else if (w_out_free) begin
                r_s1_vld <= 1'b0;
            end
            if (w_out_free) begin
                r_m_valid <= r_s1_vld;
                r_m_last  <= r_s1_vld && r_s1_last;
                r_m_test  <= r_s1_vld && r_s1_test;
                r_m_rend  <= r_s1_vld && r_s1_rend;
                if (r_s1_vld) r_m_data <= r_s1_data;
            end
            r_test_end <= r_m_valid && mReady && r_m_rend && r_m_test;
        end
    end

    assign sData_ready = r_s_ready;
    assign mValid      = r_m_valid;
    assign mData       = r_m_data;
    assign mLast       = r_m_last;
    assign Test_Signal = r_m_test;
    assign Test_End    = r_test_end;
endmodule
`default_nettype wire

// File: tb/tb_img2col_top.sv
`default_nettype none
// ============================================================================
// Module : tb_img2col_top
// Brief  : Randomized frames for img2col_top compared against a window-walk
//          reference model of the expected output stream.
// Rev    : 1.0
// ============================================================================
module tb_img2col_top;
    logic        clk = 1'b0;
    logic        reset, start;
    logic        sData_valid, sData_ready, mValid, mReady, mLast;
    logic [63:0] sData_payload, mData;
    logic [15:0] Stride, Kernel_Size, Window_Size, Sliding_Size, InFeature_Size, InFeature_Channel;
    logic [15:0] OutFeature_Channel, OutFeature_Size, OutCol_Count_Times, InCol_Count_Times;
    logic [15:0] OutRow_Count_Times, OutFeature_Channel_Count_Times, Test_Generate_Period;
    logic        Test_Signal, Test_End;

    always #5 clk = ~clk;

    img2col_top dut (
        .clk(clk), .reset(reset), .start(start),
        .sData_valid(sData_valid), .sData_ready(sData_ready), .sData_payload(sData_payload),
        .mData(mData), .mValid(mValid), .mReady(mReady), .mLast(mLast),
        .Stride(Stride), .Kernel_Size(Kernel_Size), .Window_Size(Window_Size),
        .Sliding_Size(Sliding_Size), .InFeature_Size(InFeature_Size),
        .InFeature_Channel(InFeature_Channel), .OutFeature_Channel(OutFeature_Channel),
        .OutFeature_Size(OutFeature_Size), .OutCol_Count_Times(OutCol_Count_Times),
        .InCol_Count_Times(InCol_Count_Times), .OutRow_Count_Times(OutRow_Count_Times),
        .OutFeature_Channel_Count_Times(OutFeature_Channel_Count_Times),
        .Test_Generate_Period(Test_Generate_Period),
        .Test_Signal(Test_Signal), .Test_End(Test_End)
    );

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        test;
        logic        rend;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       cur;
    logic [63:0] in_q[$];
    int          checks = 0;
    int          failures = 0;
    int          te_seen = 0;
    int          ts_seen = 0;
    bit          mon_en = 0;
    bit          gaps = 0;
    int          bp_mode = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Input source: holds a beat until accepted, optional random idle gaps
    bit acc;
    initial begin
        sData_valid = 1'b0;
        sData_payload = '0;
        forever begin
            @(negedge clk);
            acc = sData_valid && sData_ready;
            @(posedge clk);
            #1;
            if (acc && in_q.size() > 0) void'(in_q.pop_front());
            if (sData_valid && !acc && in_q.size() > 0) begin
                sData_valid = 1'b1;
            end else if (in_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                sData_valid = 1'b1;
                sData_payload = in_q[0];
            end else begin
                sData_valid = 1'b0;
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        mReady = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 0) mReady = 1'b1;
            else begin
                mReady = (cnt < 64);
                cnt = (cnt + 1) % 513;
            end
        end
    end

    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic        prev_last, prev_ts;
    logic        te_due = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                chk("hold_valid", mValid, 1);
                chk("hold_data", mData, prev_data);
                chk("hold_last", mLast, prev_last);
                chk("hold_test", Test_Signal, prev_ts);
            end
            chk("test_end", Test_End, te_due);
            if (Test_End) te_seen++;
            te_due = 1'b0;
            if (mValid && mReady) begin
                chk("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    chk("data", mData, cur.data);
                    chk("last", mLast, cur.last);
                    chk("test_sig", Test_Signal, cur.test);
                    te_due = cur.rend && cur.test;
                end
                if (Test_Signal) ts_seen++;
            end
            prev_stall = mValid && !mReady;
            prev_data  = mData;
            prev_last  = mLast;
            prev_ts    = Test_Signal;
        end else begin
            prev_stall = 1'b0;
            te_due = 1'b0;
        end
    end

    task automatic set_cfg(input int fs, ch, k, s, ofs, orow, cht, tgp);
        InFeature_Size = 16'(fs);       InFeature_Channel = 16'(ch);
        Kernel_Size = 16'(k);           Stride = 16'(s);
        Window_Size = 16'(k * ch / 8);  Sliding_Size = 16'(s * ch / 8);
        InCol_Count_Times = 16'(fs * ch / 8);
        OutFeature_Size = 16'(ofs);     OutRow_Count_Times = 16'(orow);
        OutFeature_Channel_Count_Times = 16'(cht);
        Test_Generate_Period = 16'(tgp);
        OutFeature_Channel = 16'(ch);   OutCol_Count_Times = 16'(ofs);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_frame(input string name, input int fs, ch, k, s, ofs, orow, cht, tgp,
                             input bit seq, input int extra, input bit restart, input int budget);
        int incol, win, slide, nrows, n, per_row;
        logic [63:0] img[$];
        beat_t e;
        incol = fs * ch / 8; win = k * ch / 8; slide = s * ch / 8;
        nrows = k + (orow - 1) * s;
        per_row = cht * ofs * k * win;
        for (int i = 0; i < nrows * incol; i++) img.push_back(seq ? 64'(i) : {$urandom, $urandom});
        for (int r = 0; r < orow; r++)
            for (int t = 0; t < cht; t++)
                for (int ox = 0; ox < ofs; ox++)
                    for (int ky = 0; ky < k; ky++)
                        for (int w = 0; w < win; w++) begin
                            e.data = img[(r * s + ky) * incol + ox * slide + w];
                            e.rend = (t == cht - 1) && (ox == ofs - 1) && (ky == k - 1) && (w == win - 1);
                            e.last = e.rend && (r == orow - 1);
                            e.test = (r + 1 == tgp);
                            exp_q.push_back(e);
                        end
        set_cfg(fs, ch, k, s, ofs, orow, cht, tgp);
        foreach (img[i]) in_q.push_back(img[i]);
        for (int i = 0; i < extra; i++) in_q.push_back({$urandom, $urandom});
        te_seen = 0; ts_seen = 0; mon_en = 1;
        pulse_start();
        if (restart) begin
            repeat (4) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk({name, "_in_budget"}, n < budget, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk({name, "_beats_left"}, exp_q.size(), 0);
        chk({name, "_input_left"}, in_q.size(), extra);
        chk({name, "_ready_after"}, sData_ready, 0);
        chk({name, "_test_end_cnt"}, te_seen, (tgp >= 1 && tgp <= orow) ? 1 : 0);
        chk({name, "_test_sig_cnt"}, ts_seen, (tgp >= 1 && tgp <= orow) ? per_row : 0);
        mon_en = 0;
        exp_q.delete();
        in_q.delete();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b0; start = 1'b0;
        set_cfg(4, 8, 2, 2, 2, 2, 1, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", sData_ready, 0);
        chk("rst_valid", mValid, 0);
        chk("rst_last", mLast, 0);
        chk("rst_tsig", Test_Signal, 0);
        chk("rst_tend", Test_End, 0);
        chk("rst_data", mData, 0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        run_frame("small", 4, 8, 2, 2, 2, 2, 1, 1, 1, 2, 0, 500);
        run_frame("chtimes2", 4, 8, 2, 2, 2, 2, 2, 2, 1, 0, 1, 500);
        bp_mode = 1; gaps = 1;
        run_frame("backpress", 8, 16, 3, 2, 3, 3, 2, 2, 0, 1, 0, 20000);
        bp_mode = 0;
        run_frame("maxk", 16, 8, 16, 16, 1, 1, 1, 3, 0, 0, 0, 3000);
        gaps = 0;
        run_frame("stride1", 6, 8, 3, 1, 4, 4, 1, 0, 0, 0, 0, 2000);

        // Abort a frame once output is flowing, then rerun the small frame
        set_cfg(4, 8, 2, 2, 2, 2, 1, 1);
        for (int i = 0; i < 16; i++) in_q.push_back(64'(i));
        pulse_start();
        n = 0;
        while (!mValid && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("abort_reached_emit", n < 200, 1);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ready", sData_ready, 0);
        chk("abort_valid", mValid, 0);
        chk("abort_last", mLast, 0);
        chk("abort_tsig", Test_Signal, 0);
        chk("abort_tend", Test_End, 0);
        chk("abort_data", mData, 0);
        in_q.delete();
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        run_frame("after_abort", 4, 8, 2, 2, 2, 2, 1, 1, 1, 0, 0, 500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
